// File: rtl/core_pkg.sv
// Shared core types for the EX-stage multiply sequencer.
// Op/state encodings and ALU control mapping.
package core_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } mul_state_e;

  localparam logic [4:0] ALU_MUL    = 5'h16;
  localparam logic [4:0] ALU_MULH   = 5'h17;
  localparam logic [4:0] ALU_MULHSU = 5'h18;
  localparam logic [4:0] ALU_MULHU  = 5'h19;

  // Map an ALU control code onto the multiplier op encoding.
  function automatic mul_op_e alu_to_mul_op(
    input logic [4:0] alu
  );
    mul_op_e op;
    op = MUL;
    unique case (alu)
      ALU_MULH:   op = MULH;
      ALU_MULHSU: op = MULHSU;
      ALU_MULHU:  op = MULHU;
      default:    op = MUL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add datapath: accumulator, multiplier shift
// register, multiplicand, final negate and half select.
module mul_shift_add_dp
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            fin,
  input  logic [XLEN-1:0] mcand_in,
  input  logic [XLEN-1:0] mplier_in,
  input  logic            neg,
  input  logic            sel_hi,
  output logic [XLEN-1:0] rsp_data
);

  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   rsp_q, rsp_d;
  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fin;

  // One add/shift step, plus the signed fix-up of the product.
  always_comb begin
    sum      = {1'b0, acc_q}
             + (mplier_q[0] ? {1'b0, mcand_q}
                            : {(XLEN+1){1'b0}});
    prod     = {acc_q, mplier_q};
    prod_fin = neg ? (~prod + 1'b1) : prod;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    rsp_d    = rsp_q;
    unique case (1'b1)
      load: begin
        acc_d    = '0;
        mplier_d = mplier_in;
        mcand_d  = mcand_in;
      end
      step: begin
        acc_d    = sum[XLEN:1];
        mplier_d = {sum[0], mplier_q[XLEN-1:1]};
      end
      fin: begin
        rsp_d = sel_hi ? prod_fin[2*XLEN-1:XLEN]
                       : prod_fin[XLEN-1:0];
      end
      default: begin
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      rsp_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      rsp_q    <= rsp_d;
    end
  end

  assign rsp_data = rsp_q;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Iterative multiply sequencer: FSM, iteration count,
// handshakes and operand sign handling.
module mul_seq_ctrl
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic            flush,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            busy
);

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mul_op_e          op_q, op_d;
  logic             neg_q, neg_d;

  mul_op_e          in_op;
  logic             a_neg, b_neg;
  logic [XLEN-1:0]  rs1_abs, rs2_abs;
  logic             load, step, fin;

  // Operand sign bookkeeping on the request side.
  always_comb begin
    in_op   = mul_op_e'(req_op);
    a_neg   = req_rs1[XLEN-1]
            & (in_op == MULH || in_op == MULHSU);
    b_neg   = req_rs2[XLEN-1] & (in_op == MULH);
    rs1_abs = a_neg ? (~req_rs1 + 1'b1) : req_rs1;
    rs2_abs = b_neg ? (~req_rs2 + 1'b1) : req_rs2;
  end

  // Next state; the extra CALC cycle at cnt==XLEN
  // performs the negate/select into rsp_data.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    load      = 1'b0;
    step      = 1'b0;
    fin       = 1'b0;
    req_ready = (state_q == IDLE) && !flush;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          load    = 1'b1;
          state_d = CALC;
          cnt_d   = '0;
          op_d    = in_op;
          neg_d   = a_neg ^ b_neg;
        end
      end
      CALC: begin
        if (cnt_q == CNT_W'(XLEN)) begin
          fin     = !flush;
          state_d = DONE;
        end else begin
          step  = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= MUL;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

  mul_shift_add_dp u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .step      (step),
    .fin       (fin),
    .mcand_in  (rs1_abs),
    .mplier_in (rs2_abs),
    .neg       (neg_q),
    .sel_hi    (op_q != MUL),
    .rsp_data  (rsp_data)
  );

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl with a result
// scoreboard and immediate-assertion checks.
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic        flush = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mul_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(
    input logic [1:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      2'b00: p = ua * ub;
      2'b01: p = sa * sb;
      2'b10: p = sa * ub;
      default: p = ua * ub;
    endcase
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [1:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] exp);
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    req_op    = op;
    req_rs1   = a;
    req_rs2   = b;
    req_valid = 1'b1;
    #1;
    chk("req_ready_idle", req_ready, 1'b1);
    tick();
    exp_q.push_back(exp);
    req_valid = 1'b0;
    req_rs1   = $urandom;
    req_rs2   = $urandom;
  endtask

  task automatic wait_rsp(output int lat,
                          output int nbusy);
    lat   = 0;
    nbusy = busy ? 1 : 0;
    while (!rsp_valid && lat < 60) begin
      tick();
      lat++;
      if (busy) nbusy++;
    end
    chk("rsp_seen", rsp_valid, 1'b1);
  endtask

  task automatic take_rsp(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 1'b1, 1'b0);
      e = 'x;
    end else begin
      e = exp_q.pop_front();
    end
    chk(tag, rsp_data, e);
    rsp_ready = 1'b1;
    tick();
    chk({tag, "_drop_valid"}, rsp_valid, 1'b0);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic run(input string tag,
                     input logic [1:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [31:0] exp);
    int lat, nb;
    start(op, a, b, exp);
    wait_rsp(lat, nb);
    take_rsp(tag);
  endtask

  initial begin
    int lat, nb, seen;
    logic [31:0] hold;
    logic [31:0] ra, rb;
    logic [1:0]  rop;

    #12;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();

    start(2'b00, 32'd7, 32'd6, 32'd42);
    chk("busy_after_accept", busy, 1'b1);
    wait_rsp(lat, nb);
    chk("mul_latency", lat, 33);
    chk("mul_busy_cycles", nb, 34);
    take_rsp("mul_7x6");

    run("mulh_min", 2'b01, 32'h80000000,
        32'h80000000, 32'h40000000);
    run("mul_min", 2'b00, 32'h80000000,
        32'h80000000, 32'h00000000);
    run("mulhu_ff", 2'b11, 32'hFFFFFFFF,
        32'hFFFFFFFF, 32'hFFFFFFFE);
    run("mulhsu_ff", 2'b10, 32'hFFFFFFFF,
        32'hFFFFFFFF, 32'hFFFFFFFF);
    run("mulh_ff", 2'b01, 32'hFFFFFFFF,
        32'hFFFFFFFF, 32'h00000000);
    run("mul_ff", 2'b00, 32'hFFFFFFFF,
        32'hFFFFFFFF, 32'h00000001);
    run("mulh_m3x5", 2'b01, 32'hFFFFFFFD,
        32'd5, 32'hFFFFFFFF);
    run("mul_m3x5", 2'b00, 32'hFFFFFFFD,
        32'd5, 32'hFFFFFFF1);
    run("mul_zero", 2'b00, 32'h0,
        32'h12345678, 32'h0);

    rsp_ready = 1'b0;
    start(2'b11, 32'h00012345, 32'h00067890,
          model(2'b11, 32'h00012345, 32'h00067890));
    wait_rsp(lat, nb);
    hold = rsp_data;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_data", rsp_data, hold);
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_req_ready", req_ready, 1'b0);
      chk("bp_busy", busy, 1'b1);
    end
    req_valid = 1'b0;
    take_rsp("bp_result");

    start(2'b11, 32'h00010000, 32'h00010000, 32'h0);
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", busy, 1'b0);
    chk("flush_valid", rsp_valid, 1'b0);
    exp_q.delete();
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rsp_valid) seen++;
    end
    chk("flush_no_rsp", seen, 0);

    flush     = 1'b1;
    req_valid = 1'b1;
    #1;
    chk("flush_idle_ready", req_ready, 1'b0);
    tick();
    chk("flush_idle_busy", busy, 1'b0);
    flush     = 1'b0;
    req_valid = 1'b0;

    run("mulhu_after_flush", 2'b11, 32'h00010000,
        32'h00010000, 32'h00000001);

    start(2'b01, 32'hDEADBEEF, 32'h12345678, 32'h0);
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req_ready", req_ready, 1'b1);
    chk("arst_rsp_valid", rsp_valid, 1'b0);
    chk("arst_rsp_data", rsp_data, 32'h0);
    chk("arst_busy", busy, 1'b0);
    exp_q.delete();
    #1;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      rop = 2'(i);
      ra  = $urandom;
      rb  = $urandom;
      run("rand_op", rop, ra, rb, model(rop, ra, rb));
    end

    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
